// File: rtl/econet_pkg.sv
// Shared definitions for the Econet HDLC receive path: state encoding, framing
// constants and the byte-wise reflected CRC-16-CCITT step.
package econet_pkg;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2
    } rx_state_t;

    localparam logic [7:0]  FLAG     = 8'h7E;
    localparam logic [15:0] FCS_INIT = 16'hFFFF;
    localparam logic [15:0] FCS_POLY = 16'h8408;
    localparam logic [15:0] FCS_GOOD = 16'hF0B8;

    // Eight reflected shift/xor steps, data consumed LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        c = crc_in ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ FCS_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/econet_crc16.sv
// Combinational one-byte CRC-16-CCITT (reflected) update, shared by the
// receive path and a future transmitter.
module econet_crc16
    import econet_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  byte_in,
    output logic [15:0] crc_out
);

    assign crc_out = crc16_byte(crc_in, byte_in);

endmodule

// File: rtl/econet_hdlc_rx.sv
// Econet HDLC bit receiver: flag hunt, zero destuffing, LSB-first byte assembly
// and running FCS. Define ECONET_RX_MAXLEN_EN to abort frames above MAX_FRAME bytes.
module econet_hdlc_rx
    import econet_pkg::*;
`ifdef ECONET_RX_MAXLEN_EN
#(
    parameter int MAX_FRAME = 512
)
`endif
(
    input  logic        econet_clk,
    input  logic        reset_n,
    input  logic        rx,
    output logic [7:0]  rx_byte,
    output logic [15:0] rx_fcs,
    output logic        rx_byte_ready,
    output logic        rx_frame_start,
    output logic        rx_frame_end,
    output logic        rx_abort,
    output logic        rx_idle
);

    logic        rx_q;
    logic [3:0]  ones_reg, ones_next;
    rx_state_t   state_reg, state_next;
    logic [2:0]  bit_cnt_reg, bit_cnt_next;
    logic [6:0]  shift_reg, shift_next;
    logic [7:0]  byte_in;
    logic [15:0] crc_reg, crc_next, crc_byte;
    logic [7:0]  byte_reg, byte_next;
    logic [15:0] fcs_reg, fcs_next;
    logic        byte_ready_reg, byte_ready_next;
    logic        start_reg, start_next;
    logic        end_reg, end_next;
    logic        abort_reg, abort_next;

    logic is_flag, is_stuff, is_abort, is_data, byte_done, overflow;

    // Bit classification from the run of 1s preceding the current bit.
    assign is_flag   = !rx_q && (ones_reg == 4'd6);
    assign is_stuff  = !rx_q && (ones_reg == 4'd5);
    assign is_abort  = rx_q && (ones_reg == 4'd6);
    assign is_data   = !(is_flag || is_stuff || is_abort);

    // The shifter keeps the first seven bits; the eighth arrives straight from rx_q.
    assign byte_in   = {rx_q, shift_reg};
    assign byte_done = is_data && (state_reg != HUNT) && (bit_cnt_reg == 3'd7);

`ifdef ECONET_RX_MAXLEN_EN
    logic [15:0] byte_cnt_reg, byte_cnt_next;

    assign overflow = byte_done && (byte_cnt_reg == 16'(MAX_FRAME));

    always_comb begin
        byte_cnt_next = byte_cnt_reg;
        if (is_flag) begin
            byte_cnt_next = '0;
        end else if (byte_done && !overflow) begin
            byte_cnt_next = byte_cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge econet_clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt_reg <= '0;
        end else begin
            byte_cnt_reg <= byte_cnt_next;
        end
    end
`else
    assign overflow = 1'b0;
`endif

    econet_crc16 u_crc (
        .crc_in  (crc_reg),
        .byte_in (byte_in),
        .crc_out (crc_byte)
    );

    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        crc_next        = crc_reg;
        byte_next       = byte_reg;
        fcs_next        = fcs_reg;
        byte_ready_next = 1'b0;
        start_next      = 1'b0;
        end_next        = 1'b0;
        abort_next      = 1'b0;
        ones_next       = rx_q ? ((ones_reg == 4'd15) ? 4'd15 : ones_reg + 4'd1) : 4'd0;

        case (state_reg)
            HUNT: begin
                if (is_flag) begin
                    state_next   = SYNC;
                    bit_cnt_next = 3'd0;
                    crc_next     = FCS_INIT;
                end
            end
            SYNC, DATA: begin
                if (is_flag) begin
                    // A closing flag doubles as the opening flag of the next frame.
                    end_next     = (state_reg == DATA);
                    state_next   = SYNC;
                    bit_cnt_next = 3'd0;
                    crc_next     = FCS_INIT;
                end else if (is_abort) begin
                    abort_next   = (state_reg == DATA);
                    state_next   = HUNT;
                end else if (is_data) begin
                    shift_next   = byte_in[7:1];
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (overflow) begin
                        abort_next = 1'b1;
                        state_next = HUNT;
                    end else if (byte_done) begin
                        byte_next       = byte_in;
                        crc_next        = crc_byte;
                        fcs_next        = crc_byte;
                        byte_ready_next = 1'b1;
                        start_next      = (state_reg == SYNC);
                        state_next      = DATA;
                    end
                end
            end
            default: begin
                state_next = HUNT;
            end
        endcase
    end

    always_ff @(posedge econet_clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_q           <= 1'b0;
            ones_reg       <= 4'd0;
            state_reg      <= HUNT;
            bit_cnt_reg    <= 3'd0;
            shift_reg      <= 7'd0;
            crc_reg        <= FCS_INIT;
            byte_reg       <= 8'd0;
            fcs_reg        <= FCS_INIT;
            byte_ready_reg <= 1'b0;
            start_reg      <= 1'b0;
            end_reg        <= 1'b0;
            abort_reg      <= 1'b0;
        end else begin
            rx_q           <= rx;
            ones_reg       <= ones_next;
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            crc_reg        <= crc_next;
            byte_reg       <= byte_next;
            fcs_reg        <= fcs_next;
            byte_ready_reg <= byte_ready_next;
            start_reg      <= start_next;
            end_reg        <= end_next;
            abort_reg      <= abort_next;
        end
    end

    assign rx_byte        = byte_reg;
    assign rx_fcs         = fcs_reg;
    assign rx_byte_ready  = byte_ready_reg;
    assign rx_frame_start = start_reg;
    assign rx_frame_end   = end_reg;
    assign rx_abort       = abort_reg;
    assign rx_idle        = (ones_reg == 4'd15);

endmodule

// File: tb/tb_econet_hdlc_rx.sv
// Self-checking bench for econet_hdlc_rx: frames are built at byte level, bit-stuffed
// onto the line, and the captured strobe events are compared with a frame-level model.
module tb_econet_hdlc_rx;

    logic        econet_clk = 1'b0;
    logic        reset_n    = 1'b0;
    logic        rx         = 1'b1;
    logic [7:0]  rx_byte;
    logic [15:0] rx_fcs;
    logic        rx_byte_ready, rx_frame_start, rx_frame_end, rx_abort, rx_idle;

    always #5 econet_clk = ~econet_clk;

`ifdef ECONET_RX_MAXLEN_EN
    int max_len = 4;
    econet_hdlc_rx #(.MAX_FRAME(4)) dut (
`else
    int max_len = 1000000;
    econet_hdlc_rx dut (
`endif
        .econet_clk     (econet_clk),
        .reset_n        (reset_n),
        .rx             (rx),
        .rx_byte        (rx_byte),
        .rx_fcs         (rx_fcs),
        .rx_byte_ready  (rx_byte_ready),
        .rx_frame_start (rx_frame_start),
        .rx_frame_end   (rx_frame_end),
        .rx_abort       (rx_abort),
        .rx_idle        (rx_idle)
    );

    // kind: 1 byte, 2 byte+frame_start, 3 frame_end, 4 abort, 5 stray frame_start
    typedef struct packed {
        logic [2:0]  kind;
        logic [7:0]  b;
        logic [15:0] fcs;
    } ev_t;

    typedef struct packed {
        int          n;
        logic [95:0] d;
        logic        chk;
        logic        good;
    } vec_t;

    ev_t  got[$];
    ev_t  exp_q[$];
    bit   bitq[$];
    logic [7:0] d[$];
    logic [7:0] d2[$];
    int   checks = 0;
    int   errors = 0;
    int   tx_ones = 0;
    int   run_d0 = 0, run_d1 = 0, run_d2 = 0;
    vec_t vecs [4];

    function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ v[i]) c = (c >> 1) ^ 16'h8408;
            else             c = c >> 1;
        end
        return c;
    endfunction

    function automatic logic [15:0] crc_of(input logic [7:0] q[$]);
        logic [15:0] c = 16'hFFFF;
        foreach (q[i]) c = ref_crc(c, q[i]);
        return c;
    endfunction

    // Monitor: expected rx_idle is "the bit that reached the decoder ends a run of >=15 ones".
    always @(negedge econet_clk) begin
        #1;
        if (!reset_n) begin
            run_d0 = 0; run_d1 = 0; run_d2 = 0;
        end else begin
            run_d2 = run_d1;
            run_d1 = run_d0;
            run_d0 = rx ? run_d0 + 1 : 0;
            checks++;
            if (rx_idle !== (run_d2 >= 15)) begin
                errors++;
                $display("FAIL idle @%0t: rx_idle=%b expected %b", $time, rx_idle, run_d2 >= 15);
            end
        end
        if (rx_byte_ready) got.push_back({rx_frame_start ? 3'd2 : 3'd1, rx_byte, rx_fcs});
        else if (rx_frame_start) got.push_back({3'd5, rx_byte, rx_fcs});
        if (rx_frame_end) begin
            got.push_back({3'd3, 8'h00, rx_fcs});
            checks++;
            if (rx_byte_ready || rx_frame_start) begin
                errors++;
                $display("FAIL exclusive_end @%0t: frame_end with byte_ready=%b start=%b, expected 0 0",
                         $time, rx_byte_ready, rx_frame_start);
            end
        end
        if (rx_abort) begin
            got.push_back({3'd4, 8'h00, 16'h0000});
            checks++;
            if (rx_frame_end) begin
                errors++;
                $display("FAIL exclusive_abort @%0t: abort with frame_end=1, expected 0", $time);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    task automatic put_bit(input bit b);
        bitq.push_back(b);
    endtask

    task automatic put_ones(input int n);
        for (int i = 0; i < n; i++) bitq.push_back(1'b1);
    endtask

    task automatic put_flag();
        logic [7:0] f = 8'h7E;
        for (int i = 0; i < 8; i++) bitq.push_back(f[i]);
        tx_ones = 0;
    endtask

    task automatic put_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            bitq.push_back(v[i]);
            if (v[i]) begin
                tx_ones++;
                if (tx_ones == 5) begin
                    bitq.push_back(1'b0);
                    tx_ones = 0;
                end
            end else begin
                tx_ones = 0;
            end
        end
    endtask

    // closing: 0 none, 1 flag, 2 abort (eight raw 1s)
    task automatic put_frame(input logic [7:0] q[$], input int closing);
        foreach (q[i]) put_byte(q[i]);
        if (closing == 1) put_flag();
        else if (closing == 2) put_ones(8);
    endtask

    task automatic expect_frame(input logic [7:0] q[$], input int closing);
        logic [15:0] c = 16'hFFFF;
        for (int i = 0; i < q.size(); i++) begin
            if (i == max_len) begin
                exp_q.push_back({3'd4, 8'h00, 16'h0000});
                return;
            end
            c = ref_crc(c, q[i]);
            exp_q.push_back({(i == 0) ? 3'd2 : 3'd1, q[i], c});
        end
        if (q.size() > 0) begin
            if (closing == 1) exp_q.push_back({3'd3, 8'h00, c});
            else if (closing == 2) exp_q.push_back({3'd4, 8'h00, 16'h0000});
        end
    endtask

    task automatic drive();
        while (bitq.size() > 0) begin
            @(negedge econet_clk);
            rx = bitq.pop_front();
        end
    endtask

    task automatic flush(input int n);
        put_ones(n);
        drive();
    endtask

    task automatic compare(input string name);
        checks++;
        if (got.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s count: got %0d events, expected %0d", name, got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s event %0d: got kind=%0d byte=%02h fcs=%04h, expected kind=%0d byte=%02h fcs=%04h",
                         name, i, got[i].kind, got[i].b, got[i].fcs,
                         exp_q[i].kind, exp_q[i].b, exp_q[i].fcs);
            end
        end
        $display("seg %s: %0d events observed", name, got.size());
        got.delete();
        exp_q.delete();
    endtask

    task automatic rand_payload(input int n, input bit with_fcs);
        logic [31:0] r;
        logic [15:0] f;
        d.delete();
        for (int i = 0; i < n; i++) begin
            r = $urandom();
            case ($urandom_range(0, 4))
                0: d.push_back(8'hFF);
                1: d.push_back(8'h7E);
                2: d.push_back(8'h3E);
                default: d.push_back(r[7:0]);
            endcase
        end
        if (with_fcs) begin
            f = ~crc_of(d);
            d.push_back(f[7:0]);
            d.push_back(f[15:8]);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_byte"},  32'(rx_byte), 32'h00);
        chk({tag, "_fcs"},   32'(rx_fcs), 32'hFFFF);
        chk({tag, "_ready"}, 32'(rx_byte_ready), 32'd0);
        chk({tag, "_start"}, 32'(rx_frame_start), 32'd0);
        chk({tag, "_end"},   32'(rx_frame_end), 32'd0);
        chk({tag, "_abort"}, 32'(rx_abort), 32'd0);
        chk({tag, "_idle"},  32'(rx_idle), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{n: 11, d: {"123456789", 8'h6E, 8'h90, 8'h00}, chk: 1'b1, good: 1'b1};
        vecs[1] = '{n: 3,  d: {8'hFF, 8'h7E, 8'h3E, 72'h0},     chk: 1'b0, good: 1'b0};
        vecs[2] = '{n: 11, d: {"023456789", 8'h6E, 8'h90, 8'h00}, chk: 1'b1, good: 1'b0};
        vecs[3] = '{n: 4,  d: {8'h00, 8'hFF, 8'hF8, 8'h1F, 64'h0}, chk: 1'b0, good: 1'b0};

        repeat (3) @(negedge econet_clk);
        #1;
        check_reset("reset");
        @(negedge econet_clk);
        reset_n = 1'b1;
        flush(20);

        // Table-driven frames
        for (int v = 0; v < 4; v++) begin
            int idx;
            d.delete();
            for (int i = 0; i < vecs[v].n; i++) d.push_back(vecs[v].d[95 - 8*i -: 8]);
            put_flag();
            put_frame(d, 1);
            expect_frame(d, 1);
            drive();
            flush(20);
            if (vecs[v].chk && vecs[v].n <= max_len) begin
                idx = -1;
                foreach (got[i]) if (got[i].kind == 3'd3) idx = i;
                checks++;
                if (idx < 0) begin
                    errors++;
                    $display("FAIL vec%0d residue: no frame_end seen, expected one", v);
                end else if (vecs[v].good ? (got[idx].fcs != 16'hF0B8) : (got[idx].fcs == 16'hF0B8)) begin
                    errors++;
                    $display("FAIL vec%0d residue: got %04h, expected %s F0B8", v, got[idx].fcs,
                             vecs[v].good ? "==" : "!=");
                end
            end
            compare($sformatf("vec%0d", v));
        end

        // Empty frames, then two frames sharing one flag
        put_flag(); put_flag(); put_flag();
        d  = '{8'hA5, 8'h5A};
        d2 = '{8'h01};
        put_frame(d, 1);  expect_frame(d, 1);
        put_frame(d2, 1); expect_frame(d2, 1);
        drive();
        flush(20);
        compare("shared_flag");

        // Abort after one byte, then idle rises and falls
        put_flag();
        d = '{8'hAA};
        put_frame(d, 2);
        expect_frame(d, 2);
        put_ones(20);
        drive();
        chk("idle_high", 32'(rx_idle), 32'd1);
        put_bit(1'b0); put_bit(1'b1); put_bit(1'b1);
        drive();
        chk("idle_low", 32'(rx_idle), 32'd0);
        compare("abort");
        flush(20);

        // Reset asserted during the third byte
        put_flag();
        put_byte(8'h11);
        put_byte(8'h22);
        put_bit(1'b1); put_bit(1'b1); put_bit(1'b0); put_bit(1'b0);
        d = '{8'h11, 8'h22};
        expect_frame(d, 0);
        drive();
        @(posedge econet_clk);
        #2;
        reset_n = 1'b0;
        rx = 1'b1;
        #1;
        check_reset("midreset");
        compare("pre_reset");
        repeat (2) @(negedge econet_clk);
        reset_n = 1'b1;
        tx_ones = 0;
        flush(20);
        d.delete();
        for (int i = 0; i < 11; i++) d.push_back(vecs[0].d[95 - 8*i -: 8]);
        put_flag();
        put_frame(d, 1);
        expect_frame(d, 1);
        drive();
        flush(20);
        compare("post_reset");

        // Randomized frames against the frame-level model
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    rand_payload($urandom_range(1, 8), 1'b1);
                    put_flag(); put_frame(d, 1); expect_frame(d, 1);
                end
                1: begin
                    rand_payload($urandom_range(0, 5), 1'b0);
                    put_flag(); put_frame(d, 2); expect_frame(d, 2);
                end
                2: begin
                    int nf = $urandom_range(1, 3);
                    for (int k = 0; k < nf; k++) put_flag();
                    rand_payload($urandom_range(1, 6), 1'b1);
                    put_frame(d, 1); expect_frame(d, 1);
                end
                default: begin
                    put_flag();
                    rand_payload($urandom_range(1, 5), 1'b1);
                    put_frame(d, 1); expect_frame(d, 1);
                    rand_payload($urandom_range(1, 5), 1'b1);
                    put_frame(d, 1); expect_frame(d, 1);
                end
            endcase
            drive();
            flush($urandom_range(8, 20));
            compare($sformatf("rand%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
